// File: rtl/mosfet_eval_seq.sv
// mosfet_eval_seq: sequential MOSFET evaluator.
// Accepts sessions of NUM_DEV devices (W, V_GS, V_DS), computes I_D and G_M
// per device in a two-stage pipeline and reports the extreme-I_D device
// (max for mode=0, min for mode=1) with a one-cycle out_valid strobe.
// Optional feature macro: MOSFET_SUM_EN adds sum_id, the session I_D sum.
module mosfet_eval_seq #(
    parameter int IN_W    = 3,
    parameter int VTH     = 1,
    parameter int NUM_DEV = 4,
    localparam int OUT_W  = 3 * IN_W + 1,
    localparam int IDX_W  = ($clog2(NUM_DEV) > 1) ? $clog2(NUM_DEV) : 1,
    localparam int SUM_W  = OUT_W + $clog2(NUM_DEV)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             mode,
    input  logic [IN_W-1:0]  W,
    input  logic [IN_W-1:0]  V_GS,
    input  logic [IN_W-1:0]  V_DS,
    output logic             out_valid,
    output logic [OUT_W-1:0] best_id,
    output logic [OUT_W-1:0] best_gm,
    output logic [IDX_W-1:0] best_idx
`ifdef MOSFET_SUM_EN
    ,
    output logic [SUM_W-1:0] sum_id
`endif
);

    // Internal arithmetic width: one bit of headroom over the result width.
    localparam int CW = 3 * IN_W + 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2
    } state_e;

    state_e           state_q;
    logic [IDX_W-1:0] cnt_q;
    logic             drain_q;
    logic             mode_q;

    logic             accept_s;
    logic [IDX_W-1:0] idx_s;
    logic             last_s;

    // Stage 0: captured operands of the accepted sample
    logic             s0_vld_q;
    logic             s0_first_q;
    logic             s0_last_q;
    logic [IDX_W-1:0] s0_idx_q;
    logic [IN_W-1:0]  s0_w_q;
    logic [IN_W-1:0]  s0_vgs_q;
    logic [IN_W-1:0]  s0_vds_q;

    // Stage 1: registered I_D / G_M
    logic             s1_vld_q;
    logic             s1_first_q;
    logic             s1_last_q;
    logic [IDX_W-1:0] s1_idx_q;
    logic [OUT_W-1:0] s1_id_q;
    logic [OUT_W-1:0] s1_gm_q;

    logic [CW-1:0]    ov_s;
    logic [CW-1:0]    id_full_s;
    logic [CW-1:0]    gm_full_s;
    logic [OUT_W-1:0] id_d;
    logic [OUT_W-1:0] gm_d;

    // Running best
    logic [OUT_W-1:0] best_id_q;
    logic [OUT_W-1:0] best_gm_q;
    logic [IDX_W-1:0] best_idx_q;
    logic             take_s;
    logic [OUT_W-1:0] best_id_d;
    logic [OUT_W-1:0] best_gm_d;
    logic [IDX_W-1:0] best_idx_d;

`ifdef MOSFET_SUM_EN
    logic [SUM_W-1:0] sum_q;
    logic [SUM_W-1:0] sum_d;
`endif

    // Samples are only taken while collecting; the index restarts at 0 in IDLE.
    assign accept_s = in_valid && ((state_q == ST_IDLE) || (state_q == ST_COLLECT));
    assign idx_s    = (state_q == ST_IDLE) ? {IDX_W{1'b0}} : cnt_q;
    assign last_s   = (idx_s == IDX_W'(NUM_DEV - 1));

    // Session FSM: sample counting, mode latch and the two-cycle drain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= {IDX_W{1'b0}};
            drain_q <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        mode_q <= mode;
                        if (last_s) begin
                            state_q <= ST_DRAIN;
                            cnt_q   <= {IDX_W{1'b0}};
                        end else begin
                            state_q <= ST_COLLECT;
                            cnt_q   <= IDX_W'(1);
                        end
                    end
                end
                ST_COLLECT: begin
                    if (in_valid) begin
                        if (last_s) begin
                            state_q <= ST_DRAIN;
                            cnt_q   <= {IDX_W{1'b0}};
                        end else begin
                            cnt_q <= cnt_q + IDX_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_q) begin
                        state_q <= ST_IDLE;
                        drain_q <= 1'b0;
                    end else begin
                        drain_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= {IDX_W{1'b0}};
                    drain_q <= 1'b0;
                end
            endcase
        end
    end

    // Stage 0: register the accepted sample together with its session position.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s0_vld_q   <= 1'b0;
            s0_first_q <= 1'b0;
            s0_last_q  <= 1'b0;
            s0_idx_q   <= {IDX_W{1'b0}};
            s0_w_q     <= {IN_W{1'b0}};
            s0_vgs_q   <= {IN_W{1'b0}};
            s0_vds_q   <= {IN_W{1'b0}};
        end else begin
            s0_vld_q   <= accept_s;
            s0_first_q <= accept_s && (state_q == ST_IDLE);
            s0_last_q  <= accept_s && last_s;
            s0_idx_q   <= idx_s;
            s0_w_q     <= W;
            s0_vgs_q   <= V_GS;
            s0_vds_q   <= V_DS;
        end
    end

    // Device model: cutoff, triode or saturation, floor-divided by 3.
    always_comb begin
        ov_s      = {CW{1'b0}};
        id_full_s = {CW{1'b0}};
        gm_full_s = {CW{1'b0}};
        if (CW'(s0_vgs_q) > CW'(VTH)) begin
            ov_s = CW'(s0_vgs_q) - CW'(VTH);
            if (ov_s > CW'(s0_vds_q)) begin
                id_full_s = CW'(s0_w_q) * (CW'(2) * ov_s * CW'(s0_vds_q)
                                           - CW'(s0_vds_q) * CW'(s0_vds_q));
                gm_full_s = CW'(2) * CW'(s0_w_q) * CW'(s0_vds_q);
            end else begin
                id_full_s = CW'(s0_w_q) * ov_s * ov_s;
                gm_full_s = CW'(2) * CW'(s0_w_q) * ov_s;
            end
        end else begin
            id_full_s = {CW{1'b0}};
            gm_full_s = {CW{1'b0}};
        end
        id_d = OUT_W'(id_full_s / CW'(3));
        gm_d = OUT_W'(gm_full_s / CW'(3));
    end

    // Stage 1: register the computed I_D / G_M.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld_q   <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_idx_q   <= {IDX_W{1'b0}};
            s1_id_q    <= {OUT_W{1'b0}};
            s1_gm_q    <= {OUT_W{1'b0}};
        end else begin
            s1_vld_q   <= s0_vld_q;
            s1_first_q <= s0_first_q;
            s1_last_q  <= s0_last_q;
            s1_idx_q   <= s0_idx_q;
            s1_id_q    <= id_d;
            s1_gm_q    <= gm_d;
        end
    end

    // Stage 2 selection: strict compare so ties keep the earlier device.
    always_comb begin
        take_s = 1'b0;
        if (s1_first_q) begin
            take_s = 1'b1;
        end else if (mode_q) begin
            take_s = (s1_id_q < best_id_q);
        end else begin
            take_s = (s1_id_q > best_id_q);
        end
        best_id_d  = take_s ? s1_id_q  : best_id_q;
        best_gm_d  = take_s ? s1_gm_q  : best_gm_q;
        best_idx_d = take_s ? s1_idx_q : best_idx_q;
    end

`ifdef MOSFET_SUM_EN
    // Session I_D sum restarts on the first device of each session.
    always_comb begin
        sum_d = sum_q;
        if (s1_first_q) begin
            sum_d = SUM_W'(s1_id_q);
        end else begin
            sum_d = sum_q + SUM_W'(s1_id_q);
        end
    end
`endif

    // Stage 2: update the running best and present the result on the last device.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            best_id_q  <= {OUT_W{1'b0}};
            best_gm_q  <= {OUT_W{1'b0}};
            best_idx_q <= {IDX_W{1'b0}};
            out_valid  <= 1'b0;
            best_id    <= {OUT_W{1'b0}};
            best_gm    <= {OUT_W{1'b0}};
            best_idx   <= {IDX_W{1'b0}};
`ifdef MOSFET_SUM_EN
            sum_q      <= {SUM_W{1'b0}};
            sum_id     <= {SUM_W{1'b0}};
`endif
        end else begin
            if (s1_vld_q) begin
                best_id_q  <= best_id_d;
                best_gm_q  <= best_gm_d;
                best_idx_q <= best_idx_d;
`ifdef MOSFET_SUM_EN
                sum_q      <= sum_d;
`endif
            end
            out_valid <= s1_vld_q && s1_last_q;
            best_id   <= (s1_vld_q && s1_last_q) ? best_id_d  : {OUT_W{1'b0}};
            best_gm   <= (s1_vld_q && s1_last_q) ? best_gm_d  : {OUT_W{1'b0}};
            best_idx  <= (s1_vld_q && s1_last_q) ? best_idx_d : {IDX_W{1'b0}};
`ifdef MOSFET_SUM_EN
            sum_id    <= (s1_vld_q && s1_last_q) ? sum_d      : {SUM_W{1'b0}};
`endif
        end
    end

endmodule

// File: tb/tb_mosfet_eval_seq.sv
// Scoreboard bench for mosfet_eval_seq: sessions are driven with directed and
// random samples, expected results are pushed when the last sample is issued,
// and a negedge monitor pops and compares whenever out_valid is seen.
module tb_mosfet_eval_seq;

    localparam int IN_W    = 3;
    localparam int VTH     = 1;
    localparam int NUM_DEV = 4;
    localparam int OUT_W   = 3 * IN_W + 1;
    localparam int IDX_W   = ($clog2(NUM_DEV) > 1) ? $clog2(NUM_DEV) : 1;
    localparam int SUM_W   = OUT_W + $clog2(NUM_DEV);

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             mode;
    logic [IN_W-1:0]  W;
    logic [IN_W-1:0]  V_GS;
    logic [IN_W-1:0]  V_DS;
    logic             out_valid;
    logic [OUT_W-1:0] best_id;
    logic [OUT_W-1:0] best_gm;
    logic [IDX_W-1:0] best_idx;
`ifdef MOSFET_SUM_EN
    logic [SUM_W-1:0] sum_id;
`endif

    mosfet_eval_seq #(.IN_W(IN_W), .VTH(VTH), .NUM_DEV(NUM_DEV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .mode     (mode),
        .W        (W),
        .V_GS     (V_GS),
        .V_DS     (V_DS),
        .out_valid(out_valid),
        .best_id  (best_id),
        .best_gm  (best_gm),
        .best_idx (best_idx)
`ifdef MOSFET_SUM_EN
        ,
        .sum_id   (sum_id)
`endif
    );

    typedef struct {
        int     cyc;
        int     id;
        int     gm;
        int     idx;
        longint sum;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   last_edge = 0;
    int   sw[NUM_DEV];
    int   sg[NUM_DEV];
    int   sd[NUM_DEV];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: after an edge settles, cyc is that edge's number.
    always @(posedge clk) cyc <= cyc + 1;

    // Reference device model from the square-law rules with plain integers.
    function automatic void calc(input int w, input int g, input int d,
                                 output int id, output int gm);
        int ov;
        if (g <= VTH) begin
            id = 0;
            gm = 0;
        end else begin
            ov = g - VTH;
            if (ov > d) begin
                id = (w * (2 * ov * d - d * d)) / 3;
                gm = (2 * w * d) / 3;
            end else begin
                id = (w * ov * ov) / 3;
                gm = (2 * w * ov) / 3;
            end
        end
        id = id % (1 << OUT_W);
        gm = gm % (1 << OUT_W);
    endfunction

    // Drive one cycle of inputs; they are sampled by the next rising edge.
    task automatic send(input logic v, input logic m, input int w, input int g, input int d);
        int tw, tg, td;
        tw = w; tg = g; td = d;
        in_valid = v;
        mode     = m;
        W        = tw[IN_W-1:0];
        V_GS     = tg[IN_W-1:0];
        V_DS     = td[IN_W-1:0];
        @(posedge clk);
        #1;
        last_edge = cyc;
    endtask

    task automatic idle_cycle();
        send(1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 7),
             $urandom_range(0, 7), $urandom_range(0, 7));
    endtask

    task automatic set_smp(input int i, input int w, input int g, input int d);
        sw[i] = w;
        sg[i] = g;
        sd[i] = d;
    endtask

    // Full session: sw/sg/sd are the devices, gap inserted before device gap_at,
    // n_drain in_valid pulses during the drain window (they must be dropped).
    task automatic run_session(input int md, input int gap_at, input int gap_len, input int n_drain);
        int   ids[NUM_DEV];
        int   gms[NUM_DEV];
        int   best;
        exp_t e;
        e.sum = 0;
        best  = 0;
        for (int i = 0; i < NUM_DEV; i++) begin
            calc(sw[i], sg[i], sd[i], ids[i], gms[i]);
            e.sum = e.sum + longint'(ids[i]);
            if (i == 0) best = 0;
            else if (md == 0 && ids[i] > ids[best]) best = i;
            else if (md == 1 && ids[i] < ids[best]) best = i;
        end
        for (int i = 0; i < NUM_DEV; i++) begin
            if (i == gap_at) begin
                for (int k = 0; k < gap_len; k++) idle_cycle();
            end
            send(1'b1, (i == 0) ? 1'(md) : 1'($urandom_range(0, 1)), sw[i], sg[i], sd[i]);
        end
        e.cyc = last_edge + 2;
        e.id  = ids[best];
        e.gm  = gms[best];
        e.idx = best;
        sb.push_back(e);
        for (int k = 0; k < n_drain; k++)
            send(1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 7),
                 $urandom_range(0, 7), $urandom_range(0, 7));
        for (int k = n_drain; k < 2; k++) idle_cycle();
    endtask

    // Monitor: pop and compare on every out_valid, check zeros otherwise.
    always @(negedge clk) begin
        exp_t e;
        if (out_valid === 1'b1) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_out_valid at edge %0d", cyc);
            end else begin
                e = sb.pop_front();
                if (cyc != e.cyc) begin
                    fails++;
                    $display("FAIL latency: out_valid at edge %0d, required %0d", cyc, e.cyc);
                end
                tests++;
                if (int'(best_id) != e.id) begin
                    fails++;
                    $display("FAIL best_id: got %0d, required %0d", best_id, e.id);
                end
                tests++;
                if (int'(best_gm) != e.gm) begin
                    fails++;
                    $display("FAIL best_gm: got %0d, required %0d", best_gm, e.gm);
                end
                tests++;
                if (int'(best_idx) != e.idx) begin
                    fails++;
                    $display("FAIL best_idx: got %0d, required %0d", best_idx, e.idx);
                end
`ifdef MOSFET_SUM_EN
                tests++;
                if (longint'(sum_id) != e.sum) begin
                    fails++;
                    $display("FAIL sum_id: got %0d, required %0d", sum_id, e.sum);
                end
`endif
            end
        end else begin
            tests++;
            if (out_valid !== 1'b0 || best_id !== '0 || best_gm !== '0 || best_idx !== '0
`ifdef MOSFET_SUM_EN
                || sum_id !== '0
`endif
               ) begin
                fails++;
                $display("FAIL idle_outputs at edge %0d: out_valid=%b id=%0d gm=%0d idx=%0d",
                         cyc, out_valid, best_id, best_gm, best_idx);
            end
            if (sb.size() > 0 && sb[0].cyc < cyc) begin
                e = sb.pop_front();
                tests++;
                fails++;
                $display("FAIL missing_out_valid: expected at edge %0d, none by %0d", e.cyc, cyc);
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        mode     = 1'b0;
        W        = '0;
        V_GS     = '0;
        V_DS     = '0;
        for (int k = 0; k < 3; k++) idle_cycle();
        rst_n = 1'b1;
        idle_cycle();

        // Reference session, max selection, back to back
        set_smp(0, 3, 4, 1); set_smp(1, 7, 7, 7); set_smp(2, 5, 1, 3); set_smp(3, 2, 3, 2);
        run_session(0, 0, 0, 0);
        // Same devices, min selection (cutoff device wins), starts in the out_valid cycle
        run_session(1, 0, 0, 0);
        // Gap of 3 idle cycles before device 2, two dropped pulses during drain
        run_session(0, 2, 3, 2);
        idle_cycle();

        // Ties keep the lowest index
        for (int i = 0; i < NUM_DEV; i++) set_smp(i, 3, 4, 1);
        run_session(0, 0, 0, 0);
        idle_cycle();

        // Abort after two samples with a one-cycle reset, then a fresh min session
        send(1'b1, 1'b0, 7, 7, 7);
        send(1'b1, 1'b1, 3, 4, 1);
        rst_n = 1'b0;
        idle_cycle();
        rst_n = 1'b1;
        set_smp(0, 3, 4, 1); set_smp(1, 7, 7, 7); set_smp(2, 5, 1, 3); set_smp(3, 2, 3, 2);
        run_session(1, 0, 0, 0);
        idle_cycle();

        // Region boundary: saturation at ov == V_DS, triode just above
        set_smp(0, 7, 3, 2); set_smp(1, 7, 4, 2); set_smp(2, 0, 7, 7); set_smp(3, 1, 0, 0);
        run_session(0, 0, 0, 1);
        set_smp(0, 7, 4, 2); set_smp(1, 7, 3, 2); set_smp(2, 6, 1, 5); set_smp(3, 7, 7, 7);
        run_session(1, 1, 1, 0);

        // Randomised sessions
        for (int s = 0; s < 40; s++) begin
            for (int i = 0; i < NUM_DEV; i++)
                set_smp(i, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
            run_session($urandom_range(0, 1), $urandom_range(1, NUM_DEV - 1),
                        $urandom_range(0, 3), $urandom_range(0, 2));
            if ($urandom_range(0, 2) == 0) idle_cycle();
        end

        for (int k = 0; k < 6; k++) idle_cycle();
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d results never appeared, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
